// File: rtl/gauss_scan_ctrl.sv
// gauss_scan_ctrl: band/column scan sequencer feeding the 9x9 Gaussian window
// Ports:
//   clk, n_rst            clock and synchronous active-high reset
//   start, gauss_mode     frame request and kernel/shift select (latched on start)
//   sram_re, sram_row_base, sram_col   one column read per cycle from the 9-row SRAM port
//   nineXnine_enable      shifts the returned column into the 9x9 window
//   gauss_shift           mode latched for the whole frame
//   out_valid, out_ready, out_row_base, out_col   tagged 7-pixel output column handshake
//   busy, done            frame in progress / one-cycle completion pulse
// Optional macro GAUSS_SCAN_PERF_EN adds perf_cycles and perf_stalls counters.
module gauss_scan_ctrl #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int COL_W = 10,
   parameter int ROW_W = 10
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [1:0]       gauss_mode,
   output logic             sram_re,
   output logic [ROW_W-1:0] sram_row_base,
   output logic [COL_W-1:0] sram_col,
   output logic             nineXnine_enable,
   output logic [1:0]       gauss_shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ROW_W-1:0] out_row_base,
   output logic [COL_W-1:0] out_col,
   output logic             busy,
   output logic             done
`ifdef GAUSS_SCAN_PERF_EN
   ,
   output logic [31:0]      perf_cycles,
   output logic [31:0]      perf_stalls
`endif
);
   if (IMG_W < 9 || IMG_W > (1 << COL_W) - 1) begin : g_bad_w
      $error("gauss_scan_ctrl: IMG_W out of range");
   end
   if (IMG_H < 9) begin : g_bad_h
      $error("gauss_scan_ctrl: IMG_H below 9");
   end
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 9);
   state_t           state;
   logic             re_q, en_q, stall, take;
   logic [COL_W-1:0] en_col;
   logic [ROW_W-1:0] en_row;
   logic [ROW_W:0]   step_row;
   // A held output freezes the whole pipeline; the SRAM keeps its last column
   // until the next read strobe, so suppressing the strobes loses nothing.
   assign stall            = out_valid & ~out_ready;
   assign sram_re          = re_q & ~stall;
   assign nineXnine_enable = en_q & ~stall;
   assign take             = state == IDLE && start && !done;
   assign step_row         = {1'b0, sram_row_base} + (ROW_W + 1)'(7);
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state         <= IDLE;
         re_q          <= 1'b0;
         en_q          <= 1'b0;
         en_col        <= '0;
         en_row        <= '0;
         sram_col      <= '0;
         sram_row_base <= '0;
         gauss_shift   <= '0;
         out_valid     <= 1'b0;
         out_col       <= '0;
         out_row_base  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!stall) begin
            en_q      <= re_q;
            en_col    <= sram_col;
            en_row    <= sram_row_base;
            // The first eight columns of a band only prime the window.
            out_valid <= en_q && en_col >= COL_W'(8);
            if (en_q && en_col >= COL_W'(8)) begin
               out_col      <= en_col - COL_W'(4);
               out_row_base <= en_row + ROW_W'(1);
            end
         end
         case (state)
            IDLE: if (take) begin
               state         <= SCAN;
               busy          <= 1'b1;
               gauss_shift   <= gauss_mode;
               re_q          <= 1'b1;
               sram_col      <= '0;
               sram_row_base <= '0;
            end
            SCAN: if (!stall) begin
               if (sram_col != LAST_COL)
                  sram_col <= sram_col + COL_W'(1);
               else if (sram_row_base == LAST_ROW) begin
                  re_q  <= 1'b0;
                  state <= DRAIN;
               end else begin
                  sram_col      <= '0;
                  // Final band is pulled up so it ends exactly on the last row.
                  sram_row_base <= step_row > {1'b0, LAST_ROW} ? LAST_ROW : step_row[ROW_W-1:0];
               end
            end
            DRAIN: if (!en_q && !stall) state <= DONE;
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef GAUSS_SCAN_PERF_EN
   always_ff @(posedge clk) begin
      if (n_rst || take) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else begin
         if (busy && ~&perf_cycles) perf_cycles <= perf_cycles + 32'd1;
         if (stall && ~&perf_stalls) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_gauss_scan_ctrl.sv
// tb_gauss_scan_ctrl: directed self-checking bench for gauss_scan_ctrl (16x16 and 16x20 images)
module tb_gauss_scan_ctrl;
   logic       clk = 0, n_rst = 1, start = 0, out_ready = 1;
   logic [1:0] gauss_mode = 0;
   logic       a_re, a_en, a_ov, a_busy, a_done, b_re, b_en, b_ov, b_busy, b_done;
   logic [1:0] a_gs, b_gs;
   logic [9:0] a_srb, a_sc, a_orb, a_oc, b_srb, b_sc, b_orb, b_oc;
`ifdef GAUSS_SCAN_PERF_EN
   logic [31:0] a_pc, a_ps, b_pc, b_ps;
`endif
   typedef struct {int c; int col; int row;} ev_t;
   ev_t qa[$], qb[$];
   int  a_re_q[$], a_done_q[$], b_done_q[$];
   int  cyc = 0, a_busy_n = 0, checks = 0, errors = 0;
   int  s, k, ba, bb, br, bd, bdb, bn;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gauss_scan_ctrl #(.IMG_W(16), .IMG_H(16)) ua (
      .clk(clk), .n_rst(n_rst), .start(start), .gauss_mode(gauss_mode),
      .sram_re(a_re), .sram_row_base(a_srb), .sram_col(a_sc), .nineXnine_enable(a_en),
      .gauss_shift(a_gs), .out_valid(a_ov), .out_ready(out_ready), .out_row_base(a_orb),
      .out_col(a_oc), .busy(a_busy), .done(a_done)
`ifdef GAUSS_SCAN_PERF_EN
      , .perf_cycles(a_pc), .perf_stalls(a_ps)
`endif
   );
   gauss_scan_ctrl #(.IMG_W(16), .IMG_H(20)) ub (
      .clk(clk), .n_rst(n_rst), .start(start), .gauss_mode(gauss_mode),
      .sram_re(b_re), .sram_row_base(b_srb), .sram_col(b_sc), .nineXnine_enable(b_en),
      .gauss_shift(b_gs), .out_valid(b_ov), .out_ready(out_ready), .out_row_base(b_orb),
      .out_col(b_oc), .busy(b_busy), .done(b_done)
`ifdef GAUSS_SCAN_PERF_EN
      , .perf_cycles(b_pc), .perf_stalls(b_ps)
`endif
   );

   always @(negedge clk) begin
      if (a_re) a_re_q.push_back(cyc);
      if (a_ov && out_ready) qa.push_back('{cyc, int'(a_oc), int'(a_orb)});
      if (b_ov && out_ready) qb.push_back('{cyc, int'(b_oc), int'(b_orb)});
      if (a_done) a_done_q.push_back(cyc);
      if (b_done) b_done_q.push_back(cyc);
      if (a_busy) a_busy_n++;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [1:0] m, output int st);
      @(posedge clk); #1 start = 1; gauss_mode = m; st = cyc;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic wait_both(input int da, input int db);
      int n = 0;
      while ((a_done_q.size() <= da || b_done_q.size() <= db) && n < 400) begin
         @(negedge clk); n++;
      end
      chk("frame_timeout", n < 400, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_frame(input bit isb, input int base, input int n);
      int  sz;
      ev_t e;
      sz = isb ? qb.size() : qa.size();
      chk(isb ? "b_out_count" : "a_out_count", sz - base, n);
      for (int i = 0; i < n && base + i < sz; i++) begin
         if (isb) e = qb[base+i]; else e = qa[base+i];
         chk(isb ? "b_out_col" : "a_out_col", e.col, 4 + i % 8);
         chk(isb ? "b_out_row" : "a_out_row", e.row, i < 8 ? 1 : i < 16 ? 8 : 12);
      end
   endtask

   task automatic snap();
      ba = qa.size(); bb = qb.size(); br = a_re_q.size();
      bd = a_done_q.size(); bdb = b_done_q.size(); bn = a_busy_n;
   endtask

   task automatic chk_done_timing();
      chk("a_done_count", a_done_q.size() - bd, 1);
      chk("b_done_count", b_done_q.size() - bdb, 1);
      if (a_done_q.size() > bd && qa.size() > 0)
         chk("a_done_lat", a_done_q[bd] - qa[qa.size()-1].c, 2);
      if (b_done_q.size() > bdb && qb.size() > 0)
         chk("b_done_lat", b_done_q[bdb] - qb[qb.size()-1].c, 2);
      chk("a_busy_end", a_busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 n_rst = 0;
      chk("rst_ctl", {a_re, a_en, a_ov, a_busy, a_done, a_gs}, 0);
      chk("rst_addr", {a_srb, a_sc, a_orb, a_oc}, 0);

      // Frame 1: free-running, with an ignored mid-frame start
      snap();
      pulse_start(2'd1, s);
      repeat (8) @(posedge clk);
      #1 start = 1; gauss_mode = 2;
      @(posedge clk); #1 start = 0; gauss_mode = 1;
      chk("shift_hold", a_gs, 1);
      chk("busy_mid", a_busy, 1);
      wait_both(bd, bdb);
      chk("re_count", a_re_q.size() - br, 32);
      chk("re_first", a_re_q.size() > br ? a_re_q[br] : -1, s + 1);
      chk("re_last", a_re_q.size() > 0 ? a_re_q[a_re_q.size()-1] : -1, s + 32);
      chk("out_first_cyc", qa.size() > ba ? qa[ba].c : -1, s + 11);
      chk_frame(0, ba, 16);
      chk_frame(1, bb, 24);
      chk_done_timing();
      chk("busy_cycles", a_busy_n - bn, 35);
      chk("shift_end", a_gs, 1);
`ifdef GAUSS_SCAN_PERF_EN
      chk("perf_cycles", a_pc, 35);
      chk("perf_stalls", a_ps, 0);
`endif

      // Frame 2: out_ready low for five cycles at the third output
      snap();
      pulse_start(2'd1, s);
      k = 0;
      while (!(a_ov && a_oc == 5) && k < 100) begin @(negedge clk); k++; end
      chk("stall_sync", cyc, s + 12);
      @(posedge clk); #1 out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_col", a_oc, 6);
         chk("stall_valid", a_ov, 1);
         chk("stall_re_en", {a_re, a_en}, 0);
      end
      @(posedge clk); #1 out_ready = 1;
      wait_both(bd, bdb);
      chk_frame(0, ba, 16);
      chk("stall_re_last", a_re_q.size() > 0 ? a_re_q[a_re_q.size()-1] : -1, s + 37);
      chk_done_timing();
      chk("stall_busy_cycles", a_busy_n - bn, 40);
`ifdef GAUSS_SCAN_PERF_EN
      chk("perf_stalls_5", a_ps, 5);
      chk("perf_cycles_busy", a_pc, a_busy_n - bn);
`endif

      // Frame 3: reset in band 1, then a fresh frame
      pulse_start(2'd2, s);
      repeat (20) @(posedge clk);
      #1 n_rst = 1;
      @(posedge clk); #1 n_rst = 0;
      chk("midrst_ctl", {a_re, a_en, a_ov, a_busy, a_done, a_gs}, 0);
      chk("midrst_addr", {a_srb, a_sc, a_orb, a_oc}, 0);
`ifdef GAUSS_SCAN_PERF_EN
      chk("midrst_perf", {a_pc, a_ps}, 0);
`endif
      bd = a_done_q.size();
      repeat (60) @(negedge clk);
      chk("midrst_no_done", a_done_q.size() - bd, 0);
      chk("midrst_idle", a_busy, 0);
      snap();
      pulse_start(2'd3, s);
      wait_both(bd, bdb);
      chk("fresh_re_count", a_re_q.size() - br, 32);
      chk_frame(0, ba, 16);
      chk_frame(1, bb, 24);
      chk_done_timing();
      chk("fresh_shift", a_gs, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
